reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The module SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Parameter NUM_CH, default 4, SHALL set the number of sequenced reset channels (1..16).
REQ-003 Parameter ALWAYS_ON_MASK, default 0, SHALL mark channels (bit=1) that follow the module reset only and ignore trigger, watchdog and instant reset.
REQ-004 Parameter RELEASE_GAP, default 125, SHALL set the cycles between consecutive channel releases (>=1).
REQ-005 Parameter WDG_W, default 26, SHALL set the watchdog counter and timeout width.
REQ-006 Parameters ALIVE_LOW and ALIVE_HIGH, defaults 12500000 and 1250000, SHALL set the alive-signal low and high cycles.
REQ-007 Port: clk  in  1  system clock.
REQ-008 Port: peripheral_aresetn  in  1  asynchronous active-low reset.
REQ-009 Port: reset_cfg  in  4  bit0 trigger mode, bit1 watchdog enable, bit2 master trigger, bit3 instant-reset enable.
REQ-010 Port: wdg_timeout  in  WDG_W  watchdog timeout in cycles (0 = immediate fault when enabled).
REQ-011 Port: fault_clear  in  1  single-cycle request to leave FAULT.
REQ-012 Port: trigger_in, watchdog_in, instant_reset_in  in  1 each  raw asynchronous pin levels.
REQ-013 Port: ch_aresetn  out  NUM_CH  registered active-low channel resets.
REQ-014 Port: reset_ack, alive_signal, master_trigger  out  1 each.
REQ-015 Port: reset_sts  out  32  status word.

Function
REQ-016 trigger_in, watchdog_in and instant_reset_in SHALL each pass a 2-flop synchroniser; only synchronised (_s) values are used internally.
REQ-017 Any edge on watchdog_s SHALL zero the watchdog counter the next cycle; otherwise the counter increments and saturates at all-ones (no wrap).
REQ-018 wdg_expired = reset_cfg[1] AND counter >= wdg_timeout.
REQ-019 go = (reset_cfg[0]==0 OR trigger_s) AND NOT (reset_cfg[3] AND instant_reset_s).
REQ-020 FSM states: HOLD, RELEASE, RUN, FAULT; reset state HOLD.
REQ-021 HOLD: all sequenced channels low; go AND NOT wdg_expired -> RELEASE with index 0, gap counter 0.
REQ-022 RELEASE: gap counter counts to RELEASE_GAP-1, then channel[index] goes high and index increments; after channel NUM_CH-1 is released -> RUN.
REQ-023 First release SHALL occur RELEASE_GAP cycles after entering RELEASE; channels release in ascending order; released channels stay high.
REQ-024 RELEASE/RUN with go low -> HOLD; all sequenced channels low on the next clk edge (no staging on assertion).
REQ-025 Any state with wdg_expired -> FAULT; wdg_expired has priority over go and fault_clear in the same cycle.
REQ-026 FAULT: all sequenced channels low; leave to HOLD only when fault_clear=1 AND NOT wdg_expired; fault_clear in other states is ignored.
REQ-027 Sticky fault flag SHALL set on FAULT entry and clear only when FAULT is exited.
REQ-028 ALWAYS_ON_MASK channels SHALL go high the first cycle after reset release and stay high.
REQ-029 reset_ack SHALL equal watchdog_s registered; master_trigger SHALL equal reset_cfg[2] registered.
REQ-030 Alive counter SHALL run 0..ALIVE_LOW+ALIVE_HIGH-1 and wrap; alive_signal is low for counts < ALIVE_LOW, else high.
REQ-031 reset_sts: [15:0] ch_aresetn zero-extended, [17:16] state (HOLD=0, RELEASE=1, RUN=2, FAULT=3), [18] fault flag, [19] trigger_s, [20] watchdog_s, [21] instant_reset_s, [22] wdg_expired, [31:23] zero.

Reset
REQ-032 While peripheral_aresetn=0: ch_aresetn all 0, state HOLD, fault flag 0, all counters and synchronisers 0, alive_signal 0, reset_ack 0, master_trigger 0.
REQ-033 Assertion of peripheral_aresetn mid-RELEASE SHALL force all outputs to reset values immediately, without waiting for clk.

Verification (NUM_CH=4, RELEASE_GAP=3, ALWAYS_ON_MASK=4'b0001, wdg_timeout=100)
REQ-034 reset_cfg=0, release reset -> ch_aresetn[0]=1 after 1 cycle; bits 1,2,3 rise 3 cycles apart; state RUN.
REQ-035 reset_cfg=1, trigger_in low 50 cycles then high -> ch[3:1] stay 0 until 2 sync cycles plus staged release; trigger low in RUN -> ch[3:1]=0 one cycle after trigger_s falls.
REQ-036 reset_cfg=2, watchdog toggled every 50 cycles, then held 120 cycles -> FAULT at counter 100, sts[18]=1; fault_clear while still stalled -> stays FAULT; resume toggling and pulse fault_clear -> HOLD, then restaged release.
REQ-037 reset_cfg=8 in RUN, instant_reset_in pulse of 10 cycles -> ch[3:1]=0 during pulse, ch[0]=1 throughout, restaged release after pulse.
REQ-038 Async reset asserted mid-RELEASE (index 2) -> ch_aresetn=0 immediately; on release, sequence restarts from channel 1.
REQ-039 wdg_timeout=0 with reset_cfg=2 -> FAULT one cycle after reset release; counter saturates without wrapping after 2^WDG_W cycles of stall.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: releases NUM_CH active-low resets one by one after a start
// condition, drops them together on loss of that condition, and latches a watchdog fault.
module reset_sequencer #(
    parameter int                NUM_CH         = 4,
    parameter logic [NUM_CH-1:0] ALWAYS_ON_MASK = '0,
    parameter int                RELEASE_GAP    = 125,
    parameter int                WDG_W          = 26,
    parameter int                ALIVE_LOW      = 12500000,
    parameter int                ALIVE_HIGH     = 1250000
) (
    input  logic              clk,
    input  logic              peripheral_aresetn,
    input  logic [3:0]        reset_cfg,
    input  logic [WDG_W-1:0]  wdg_timeout,
    input  logic              fault_clear,
    input  logic              trigger_in,
    input  logic              watchdog_in,
    input  logic              instant_reset_in,
    output logic [NUM_CH-1:0] ch_aresetn,
    output logic              reset_ack,
    output logic              alive_signal,
    output logic              master_trigger,
    output logic [31:0]       reset_sts
);

    localparam int IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GAP_W        = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
    localparam int ALIVE_PERIOD = ALIVE_LOW + ALIVE_HIGH;
    localparam int ALIVE_W      = (ALIVE_PERIOD > 1) ? $clog2(ALIVE_PERIOD) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_CH - 1);
    localparam logic [GAP_W-1:0]   GAP_END     = GAP_W'(RELEASE_GAP - 1);
    localparam logic [ALIVE_W-1:0] ALIVE_LAST  = ALIVE_W'(ALIVE_PERIOD - 1);
    localparam logic [ALIVE_W-1:0] ALIVE_START = ALIVE_W'(ALIVE_LOW);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [GAP_W-1:0]    gap;
    logic [NUM_CH-1:0]   ch_q;
    logic                fault_flag;
    logic [1:0]          trig_sync, wdg_sync, inst_sync;
    logic [WDG_W-1:0]    wdg_cnt;
    logic [ALIVE_W-1:0]  alive_cnt, alive_next;
    logic                trigger_s, watchdog_s, instant_reset_s;
    logic                wdg_expired, go;

    // NOTE: every flop, including the synchronisers, sits on the async reset so the
    // channel outputs collapse the moment peripheral_aresetn falls, clock or not.
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            trig_sync <= '0;
            wdg_sync  <= '0;
            inst_sync <= '0;
        end else begin
            trig_sync <= {trig_sync[0], trigger_in};
            wdg_sync  <= {wdg_sync[0], watchdog_in};
            inst_sync <= {inst_sync[0], instant_reset_in};
        end
    end

    assign trigger_s       = trig_sync[1];
    assign watchdog_s      = wdg_sync[1];
    assign instant_reset_s = inst_sync[1];

    // reset_ack is the one-cycle-old watchdog level, so it doubles as the edge reference.
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            wdg_cnt        <= '0;
            reset_ack      <= 1'b0;
            master_trigger <= 1'b0;
        end else begin
            reset_ack      <= watchdog_s;
            master_trigger <= reset_cfg[2];
            if (watchdog_s != reset_ack) begin
                wdg_cnt <= '0;
            end else if (wdg_cnt != '1) begin
                wdg_cnt <= wdg_cnt + 1'b1;
            end
        end
    end

    assign wdg_expired = reset_cfg[1] && (wdg_cnt >= wdg_timeout);
    assign go          = (!reset_cfg[0] || trigger_s) && !(reset_cfg[3] && instant_reset_s);

    // NOTE: default assignment first so no path through the block leaves it unassigned.
    always_comb begin
        alive_next = alive_cnt + 1'b1;
        if (alive_cnt == ALIVE_LAST) begin
            alive_next = '0;
        end
    end

    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            alive_cnt    <= '0;
            alive_signal <= 1'b0;
        end else begin
            alive_cnt    <= alive_next;
            alive_signal <= (alive_next >= ALIVE_START);
        end
    end

    // Watchdog expiry outranks go and fault_clear in every state.
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            state      <= HOLD;
            idx        <= '0;
            gap        <= '0;
            ch_q       <= '0;
            fault_flag <= 1'b0;
        end else if (wdg_expired) begin
            state      <= FAULT;
            fault_flag <= 1'b1;
            ch_q       <= ALWAYS_ON_MASK;
        end else begin
            case (state)
                HOLD: begin
                    ch_q <= ALWAYS_ON_MASK;
                    if (go) begin
                        state <= RELEASE;
                        idx   <= '0;
                        gap   <= '0;
                    end
                end
                RELEASE: begin
                    if (!go) begin
                        state <= HOLD;
                        ch_q  <= ALWAYS_ON_MASK;
                    end else if (gap == GAP_END) begin
                        ch_q <= ch_q | ALWAYS_ON_MASK | (NUM_CH'(1) << idx);
                        gap  <= '0;
                        if (idx == LAST_IDX) begin
                            state <= RUN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        ch_q <= ch_q | ALWAYS_ON_MASK;
                        gap  <= gap + 1'b1;
                    end
                end
                RUN: begin
                    if (!go) begin
                        state <= HOLD;
                        ch_q  <= ALWAYS_ON_MASK;
                    end else begin
                        ch_q <= ch_q | ALWAYS_ON_MASK;
                    end
                end
                FAULT: begin
                    ch_q <= ALWAYS_ON_MASK;
                    if (fault_clear) begin
                        state      <= HOLD;
                        fault_flag <= 1'b0;
                    end
                end
                default: begin
                    state <= HOLD;
                    ch_q  <= ALWAYS_ON_MASK;
                end
            endcase
        end
    end

    assign ch_aresetn = ch_q;

    always_comb begin
        reset_sts             = '0;
        reset_sts[NUM_CH-1:0] = ch_q;
        reset_sts[17:16]      = state;
        reset_sts[18]         = fault_flag;
        reset_sts[19]         = trigger_s;
        reset_sts[20]         = watchdog_s;
        reset_sts[21]         = instant_reset_s;
        reset_sts[22]         = wdg_expired;
    end

endmodule
